// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
//   rx_state_e   : receiver FSM states
//   PAR_EVEN/ODD : encodings of the par_typ input
//   vote_tick()  : tick index of the k-th (0..2) majority-vote sample in a bit
//   majority3()  : 2-of-3 vote
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Samples sit at PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1 around mid-bit.
  function automatic int unsigned vote_tick(input int unsigned prescale,
                                            input int unsigned idx);
    return prescale / 2 - 1 + idx;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end of the UART receiver: 2-flop synchroniser, start-edge
// detector, per-bit tick counter and 3-sample majority vote.
//   clk, rst       : clock, asynchronous active-low reset
//   rx_in          : raw serial line
//   run_i          : tick counter runs while high (frame in progress)
//   bit_val_o      : voted value of the current bit (valid at bit_done_o)
//   bit_done_o     : strobe on the last tick of each bit
//   start_edge_o   : synchronised falling edge (prev 1, current 0)
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic run_i,
  output logic bit_val_o,
  output logic bit_done_o,
  output logic start_edge_o
);

  localparam int unsigned TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(PRESCALE - 1);
  localparam logic [TW-1:0] T_V0   = TW'(vote_tick(PRESCALE, 0));
  localparam logic [TW-1:0] T_V1   = TW'(vote_tick(PRESCALE, 1));
  localparam logic [TW-1:0] T_V2   = TW'(vote_tick(PRESCALE, 2));

  logic          sync1_q, sync2_q, prev_q;
  logic [1:0]    fill_q;
  logic [TW-1:0] tick_q;
  logic          s0_q, s1_q, bit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
      tick_q  <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      bit_q   <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      // The synchroniser holds its reset value of 1 for two edges after
      // release. prev only follows the line once that fake high is flushed,
      // so a line held low through reset never looks like a falling edge.
      fill_q  <= {fill_q[0], 1'b1};
      prev_q  <= fill_q[1] ? sync2_q : 1'b0;

      // Tick 0 of the start bit is the IDLE cycle that sees the edge.
      if (!run_i || tick_q == T_LAST) tick_q <= '0;
      else                            tick_q <= tick_q + 1'b1;

      if (run_i) begin
        if (tick_q == T_V0) s0_q  <= sync2_q;
        if (tick_q == T_V1) s1_q  <= sync2_q;
        if (tick_q == T_V2) bit_q <= majority3(s0_q, s1_q, sync2_q);
      end
    end
  end

  assign start_edge_o = prev_q & ~sync2_q;
  assign bit_done_o   = run_i & (tick_q == T_LAST);
  assign bit_val_o    = bit_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frames LSB-first data with optional parity and one stop bit,
// presenting each good word as a one-cycle valid pulse.
//   clk, rst       : clock, asynchronous active-low reset
//   rx_in          : serial line, idle high, asynchronous to clk
//   par_en/par_typ : parity enable / type (0 even, 1 odd), latched at start
//   rx_p_data      : last good received word
//   rx_data_valid  : one-cycle pulse, rx_p_data just updated
//   parity_error   : one-cycle pulse, bad parity at end of frame
//   stop_error     : one-cycle pulse, stop bit sampled low
//   rx_busy        : high whenever the FSM is not IDLE
//   dbg_state_o    : current FSM state (rx_state_e encoding)
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] rx_p_data,
  output logic                  rx_data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  rx_busy,
  output logic [2:0]            dbg_state_o
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);

  rx_state_e             state_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q, rx_p_data_q;
  logic                  par_en_q, par_typ_q, par_err_q;
  logic                  valid_q, perr_q, serr_q, busy_q;

  logic bit_val, bit_done, start_edge, run;

  assign run = (state_q != ST_IDLE) | start_edge;

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .run_i        (run),
    .bit_val_o    (bit_val),
    .bit_done_o   (bit_done),
    .start_edge_o (start_edge)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_p_data_q <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= PAR_EVEN;
      par_err_q   <= 1'b0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_q   <= ST_START;
            busy_q    <= 1'b1;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            par_err_q <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            if (bit_val) begin
              // Start bit voted high: it was a glitch, drop silently.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shreg_q <= {bit_val, shreg_q[DATA_WIDTH-1:1]};
            if (bit_cnt_q == BIT_LAST) state_q <= par_en_q ? ST_PARITY : ST_STOP;
            else                       bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            // Expected parity bit is ^data, inverted for odd parity.
            par_err_q <= bit_val ^ (^shreg_q) ^ par_typ_q;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (par_err_q || !bit_val) begin
              perr_q <= par_err_q;
              serr_q <= ~bit_val;
            end else begin
              rx_p_data_q <= shreg_q;
              valid_q     <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_p_data     = rx_p_data_q;
  assign rx_data_valid = valid_q;
  assign parity_error  = perr_q;
  assign stop_error    = serr_q;
  assign rx_busy       = busy_q;
  assign dbg_state_o   = state_q;

endmodule
